// File: rtl/mosby_pkg.sv
// Shared types and constants for the interrupt sequencer: state/source enums,
// vector addresses, push byte selects and the registered control bundle.
package mosby_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic [2:0] {
      ST_RESET_VL,
      ST_RESET_VH,
      ST_IDLE,
      ST_PUSH_PCH,
      ST_PUSH_PCL,
      ST_PUSH_P,
      ST_VEC_L,
      ST_VEC_H
   } seq_state_e;

   typedef enum logic [1:0] {
      SRC_RESET,
      SRC_NMI,
      SRC_BRK,
      SRC_IRQ
   } int_src_e;

   localparam logic [ADDR_W-1:0] VEC_NMI   = 16'hFFFA;
   localparam logic [ADDR_W-1:0] VEC_RESET = 16'hFFFC;
   localparam logic [ADDR_W-1:0] VEC_IRQ   = 16'hFFFE;

   // P_BRK tells the data path to insert B=1 into the pushed status byte
   localparam logic [SEL_W-1:0] PUSH_SEL_PCH   = 2'd0;
   localparam logic [SEL_W-1:0] PUSH_SEL_PCL   = 2'd1;
   localparam logic [SEL_W-1:0] PUSH_SEL_P     = 2'd2;
   localparam logic [SEL_W-1:0] PUSH_SEL_P_BRK = 2'd3;

   typedef struct packed {
      logic              flush;
      logic              normal;
      logic              busy;
      logic              push_en;
      logic [SEL_W-1:0]  push_sel;
      logic [ADDR_W-1:0] vec_addr;
      logic              vec_rd;
      logic              load_pcl;
      logic              load_pch;
      logic              set_i;
   } seq_ctl_t;

   localparam seq_ctl_t CTL_RESET = '{
      flush:    1'b1,
      normal:   1'b0,
      busy:     1'b1,
      push_en:  1'b0,
      push_sel: PUSH_SEL_PCH,
      vec_addr: 16'h0000,
      vec_rd:   1'b0,
      load_pcl: 1'b0,
      load_pch: 1'b0,
      set_i:    1'b0
   };

   // Low vector byte address for a service source; the high byte is +1
   function automatic logic [ADDR_W-1:0] vec_base(input int_src_e src);
      logic [ADDR_W-1:0] v;
      case (src)
         SRC_NMI:   v = VEC_NMI;
         SRC_RESET: v = VEC_RESET;
         default:   v = VEC_IRQ;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Two-flop synchronizer on nmi_n plus a registered one-cycle falling-edge pulse.
module nmi_edge_detect (
   input  logic clk_2,
   input  logic rst,
   input  logic nmi_n,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   // History resets high so a low nmi_n at reset release still reads as an edge
   always_ff @(posedge clk_2 or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         hist_q <= 1'b1;
         fall   <= 1'b0;
      end else begin
         meta_q <= nmi_n;
         sync_q <= meta_q;
         hist_q <= sync_q;
         fall   <= hist_q & ~sync_q;
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/BRK/IRQ service sequencer: pushes PC and P, fetches the vector.
// NMI handling is present only when NMI_SEQ_EN is defined.
module interrupt_sequencer
   import mosby_pkg::*;
(
   input  logic                clk_2,
   input  logic                rst,
   input  logic                nmi_n,
   input  logic                irq_n,
   input  logic                brk_req,
   input  logic                i_flag,
   input  logic                instr_boundary,
   output logic                flush,
   output logic                normal,
   output logic                push_en,
   output logic [SEL_W-1:0]    push_sel,
   output logic [ADDR_W-1:0]   vec_addr,
   output logic                vec_rd,
   output logic                load_pcl,
   output logic                load_pch,
   output logic                set_i,
   output logic                busy
);

   seq_state_e state_q;
   seq_state_e state_nx;
   int_src_e   src_q;
   int_src_e   src_nx;
   seq_ctl_t   ctl_q;
   seq_ctl_t   ctl_nx;

   logic boot_q;
   logic brk_pend_q;
   logic nmi_pend;
   logic irq_act;
   logic brk_any;
   logic accept;

`ifdef NMI_SEQ_EN
   logic nmi_fall;
   logic nmi_pend_q;

   nmi_edge_detect u_nmi_edge (
      .clk_2 (clk_2),
      .rst   (rst),
      .nmi_n (nmi_n),
      .fall  (nmi_fall)
   );

   // A new edge while already pending merges into the single pending request
   always_ff @(posedge clk_2 or negedge rst) begin
      if (!rst) begin
         nmi_pend_q <= 1'b0;
      end else if (nmi_fall) begin
         nmi_pend_q <= 1'b1;
      end else if (accept && (src_nx == SRC_NMI)) begin
         nmi_pend_q <= 1'b0;
      end
   end

   assign nmi_pend = nmi_pend_q;
`else
   logic unused_nmi_n;
   assign unused_nmi_n = nmi_n;
   assign nmi_pend     = 1'b0;
`endif

   assign irq_act = !irq_n && !i_flag;
   assign brk_any = brk_req || brk_pend_q;
   assign accept  = (state_q == ST_IDLE) && instr_boundary && (nmi_pend || brk_any || irq_act);

   // Next state and latched source
   always_comb begin
      state_nx = state_q;
      src_nx   = src_q;
      case (state_q)
         ST_RESET_VL: state_nx = boot_q ? ST_RESET_VL : ST_RESET_VH;
         ST_RESET_VH: state_nx = ST_IDLE;
         ST_IDLE: begin
            if (accept) begin
               state_nx = ST_PUSH_PCH;
               if (nmi_pend) begin
                  src_nx = SRC_NMI;
               end else if (brk_any) begin
                  src_nx = SRC_BRK;
               end else begin
                  src_nx = SRC_IRQ;
               end
            end
         end
         ST_PUSH_PCH: state_nx = ST_PUSH_PCL;
         ST_PUSH_PCL: state_nx = ST_PUSH_P;
         ST_PUSH_P:   state_nx = ST_VEC_L;
         ST_VEC_L:    state_nx = ST_VEC_H;
         ST_VEC_H:    state_nx = ST_IDLE;
         default:     state_nx = ST_RESET_VL;
      endcase
   end

   // Control decode of the upcoming state, so registered outputs line up with it
   always_comb begin
      ctl_nx          = CTL_RESET;
      ctl_nx.push_sel = PUSH_SEL_PCH;
      case (state_nx)
         ST_IDLE: begin
            ctl_nx.flush  = 1'b0;
            ctl_nx.normal = 1'b1;
            ctl_nx.busy   = 1'b0;
         end
         ST_PUSH_PCH: begin
            ctl_nx.push_en  = 1'b1;
            ctl_nx.push_sel = PUSH_SEL_PCH;
         end
         ST_PUSH_PCL: begin
            ctl_nx.push_en  = 1'b1;
            ctl_nx.push_sel = PUSH_SEL_PCL;
         end
         ST_PUSH_P: begin
            ctl_nx.push_en  = 1'b1;
            ctl_nx.push_sel = (src_nx == SRC_BRK) ? PUSH_SEL_P_BRK : PUSH_SEL_P;
         end
         ST_VEC_L: begin
            ctl_nx.vec_addr = vec_base(src_nx);
            ctl_nx.vec_rd   = 1'b1;
            ctl_nx.load_pcl = 1'b1;
         end
         ST_VEC_H: begin
            ctl_nx.vec_addr = vec_base(src_nx) + 16'd1;
            ctl_nx.vec_rd   = 1'b1;
            ctl_nx.load_pch = 1'b1;
            ctl_nx.set_i    = 1'b1;
         end
         ST_RESET_VL: begin
            ctl_nx.vec_addr = VEC_RESET;
            ctl_nx.vec_rd   = 1'b1;
            ctl_nx.load_pcl = 1'b1;
         end
         ST_RESET_VH: begin
            ctl_nx.vec_addr = VEC_RESET + 16'd1;
            ctl_nx.vec_rd   = 1'b1;
            ctl_nx.load_pch = 1'b1;
            ctl_nx.set_i    = 1'b1;
         end
         default: ctl_nx = CTL_RESET;
      endcase
   end

   // boot_q holds RESET_VL one extra clock so its vector fetch is visible after release
   always_ff @(posedge clk_2 or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RESET_VL;
         src_q      <= SRC_RESET;
         boot_q     <= 1'b1;
         brk_pend_q <= 1'b0;
         ctl_q      <= CTL_RESET;
      end else begin
         state_q <= state_nx;
         src_q   <= src_nx;
         boot_q  <= 1'b0;
         ctl_q   <= ctl_nx;
         if (accept) begin
            brk_pend_q <= 1'b0;
         end else if (brk_req) begin
            brk_pend_q <= 1'b1;
         end
      end
   end

   assign flush    = ctl_q.flush;
   assign normal   = ctl_q.normal;
   assign busy     = ctl_q.busy;
   assign push_en  = ctl_q.push_en;
   assign push_sel = ctl_q.push_sel;
   assign vec_addr = ctl_q.vec_addr;
   assign vec_rd   = ctl_q.vec_rd;
   assign load_pcl = ctl_q.load_pcl;
   assign load_pch = ctl_q.load_pch;
   assign set_i    = ctl_q.set_i;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus queues expected busy-cycle
// outputs, a monitor compares every cycle (reset, busy and idle).
`timescale 1ns/1ps
module tb_interrupt_sequencer;

   logic        clk_2 = 1'b0;
   logic        rst = 1'b0;
   logic        nmi_n = 1'b1;
   logic        irq_n = 1'b1;
   logic        brk_req = 1'b0;
   logic        i_flag = 1'b0;
   logic        instr_boundary = 1'b0;
   logic        flush, normal, push_en, vec_rd, load_pcl, load_pch, set_i, busy;
   logic [1:0]  push_sel;
   logic [15:0] vec_addr;

   typedef struct packed {
      logic        flush;
      logic        normal;
      logic        busy;
      logic        push_en;
      logic [1:0]  push_sel;
      logic [15:0] vec_addr;
      logic        vec_rd;
      logic        load_pcl;
      logic        load_pch;
      logic        set_i;
   } obs_t;

   localparam obs_t IDLE_OBS  = '{flush:1'b0, normal:1'b1, busy:1'b0, push_en:1'b0, push_sel:2'd0,
                                  vec_addr:16'h0000, vec_rd:1'b0, load_pcl:1'b0, load_pch:1'b0, set_i:1'b0};
   localparam obs_t RESET_OBS = '{flush:1'b1, normal:1'b0, busy:1'b1, push_en:1'b0, push_sel:2'd0,
                                  vec_addr:16'h0000, vec_rd:1'b0, load_pcl:1'b0, load_pch:1'b0, set_i:1'b0};

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic done = 1'b0;
   logic checked = 1'b0;

   interrupt_sequencer dut (
      .clk_2          (clk_2),
      .rst            (rst),
      .nmi_n          (nmi_n),
      .irq_n          (irq_n),
      .brk_req        (brk_req),
      .i_flag         (i_flag),
      .instr_boundary (instr_boundary),
      .flush          (flush),
      .normal         (normal),
      .push_en        (push_en),
      .push_sel       (push_sel),
      .vec_addr       (vec_addr),
      .vec_rd         (vec_rd),
      .load_pcl       (load_pcl),
      .load_pch       (load_pch),
      .set_i          (set_i),
      .busy           (busy)
   );

   always #5 clk_2 = ~clk_2;

   function automatic obs_t mk(input logic pe, input logic [1:0] ps, input logic [15:0] va,
                               input logic vr, input logic lpl, input logic lph, input logic si);
      obs_t o;
      o = '{flush:1'b1, normal:1'b0, busy:1'b1, push_en:pe, push_sel:ps,
            vec_addr:va, vec_rd:vr, load_pcl:lpl, load_pch:lph, set_i:si};
      return o;
   endfunction

   task automatic push_service(input logic [15:0] lo, input logic [15:0] hi, input logic [1:0] psel_p);
      exp_q.push_back(mk(1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, psel_p, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 2'd0, lo, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 2'd0, hi, 1'b1, 1'b0, 1'b1, 1'b1));
   endtask

   task automatic push_reset();
      exp_q.push_back(mk(1'b0, 2'd0, 16'hFFFC, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 2'd0, 16'hFFFD, 1'b1, 1'b0, 1'b1, 1'b1));
   endtask

   task automatic step();
      @(negedge clk_2);
      #2;
   endtask

   task automatic boundary_pulse();
      instr_boundary = 1'b1;
      step();
      instr_boundary = 1'b0;
   endtask

   // Monitor: samples 1ns after each falling clock edge and on reset assertion
   always begin
      obs_t act;
      obs_t exp;
      @(negedge clk_2 or negedge rst);
      #1;
      act = '{flush:flush, normal:normal, busy:busy, push_en:push_en, push_sel:push_sel,
              vec_addr:vec_addr, vec_rd:vec_rd, load_pcl:load_pcl, load_pch:load_pch, set_i:set_i};
      if (!rst) begin
         n_cmp++;
         if (act !== RESET_OBS) begin
            n_bad++;
            $display("FAIL reset_outputs: actual %h required %h at %0t", act, RESET_OBS, $time);
         end
      end else if (busy) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_busy: actual %h required idle at %0t", act, $time);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               n_bad++;
               $display("FAIL seq_step: actual %h required %h at %0t", act, exp, $time);
            end
         end
      end else begin
         n_cmp++;
         if (act !== IDLE_OBS) begin
            n_bad++;
            $display("FAIL idle_outputs: actual %h required %h at %0t", act, IDLE_OBS, $time);
         end
      end
      if (done && !checked) begin
         n_cmp++;
         if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expect: actual %0d pending required 0", exp_q.size());
         end
         checked = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      // Power-on reset held for 3 cycles, then the reset vector fetch
      repeat (3) step();
      push_reset();
      rst = 1'b1;
      repeat (4) step();

      // Unmasked IRQ at a boundary
      irq_n  = 1'b0;
      i_flag = 1'b0;
      push_service(16'hFFFE, 16'hFFFF, 2'd2);
      boundary_pulse();
      repeat (5) step();
      i_flag = 1'b1;
      irq_n  = 1'b1;
      repeat (2) step();
      i_flag = 1'b0;

      // Masked IRQ with a boundary every cycle: never serviced
      irq_n          = 1'b0;
      i_flag         = 1'b1;
      instr_boundary = 1'b1;
      repeat (20) step();
      instr_boundary = 1'b0;
      irq_n          = 1'b1;
      i_flag         = 1'b0;
      step();

      // NMI edge arrives mid IRQ service, taken at the next boundary
      irq_n = 1'b0;
      push_service(16'hFFFE, 16'hFFFF, 2'd2);
      boundary_pulse();
      nmi_n = 1'b0;
      repeat (5) step();
      irq_n = 1'b1;
`ifdef NMI_SEQ_EN
      push_service(16'hFFFA, 16'hFFFB, 2'd2);
`endif
      boundary_pulse();
      repeat (6) step();
      nmi_n = 1'b1;
      repeat (4) step();
      boundary_pulse();
      repeat (2) step();

      // BRK and live IRQ on the same boundary: BRK wins, IRQ then masked
      irq_n  = 1'b0;
      i_flag = 1'b0;
      push_service(16'hFFFE, 16'hFFFF, 2'd3);
      brk_req        = 1'b1;
      instr_boundary = 1'b1;
      step();
      brk_req        = 1'b0;
      instr_boundary = 1'b0;
      repeat (5) step();
      i_flag = 1'b1;
      boundary_pulse();
      repeat (3) step();
      irq_n  = 1'b1;
      i_flag = 1'b0;

      // BRK pulse ahead of the boundary stays pending until accepted
      brk_req = 1'b1;
      step();
      brk_req = 1'b0;
      step();
      push_service(16'hFFFE, 16'hFFFF, 2'd3);
      boundary_pulse();
      repeat (6) step();

      // Reset asserted while in PUSH_PCL aborts the sequence
      irq_n = 1'b0;
      push_service(16'hFFFE, 16'hFFFF, 2'd2);
      boundary_pulse();
      step();
      rst = 1'b0;
      exp_q.delete();
      irq_n = 1'b1;
      repeat (3) step();
      push_reset();
      rst = 1'b1;
      repeat (4) step();

      done = 1'b1;
      for (int i = 0; i < 10 && !checked; i++) step();
      if (!checked) begin
         $display("FAIL final_check: actual not reached required reached");
         $fatal(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
